// File: rtl/data_point_loader_pkg.sv
// Shared types and default sizes for the data-point loader and its row packer.
// The FSM state enum lives here so datapath and memory-side code agree on encoding.
package data_point_loader_pkg;

    localparam int DPL_WORD_WIDTH   = 16;
    localparam int DPL_MAX_FEATURES = 11;
    localparam int FEAT_CNT_WIDTH   = 4;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        GAP,
        FINISH
    } state_t;

endpackage

// File: rtl/data_point_loader_row_packer.sv
// Row packer: counts accepted words of one data point and places each in its slot.
// Features fill slots 0..n-1 in arrival order; the final word (y) always lands in the top slot.
module row_packer
    import data_point_loader_pkg::*;
#(
    parameter int WORD_WIDTH   = DPL_WORD_WIDTH,
    parameter int MAX_FEATURES = DPL_MAX_FEATURES,
    parameter int DATA_WIDTH   = WORD_WIDTH * (MAX_FEATURES + 1)
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      clear,
    input  logic                      accept,
    input  logic [WORD_WIDTH-1:0]     word,
    input  logic [FEAT_CNT_WIDTH-1:0] num_features,
    output logic                      last,
    output logic [DATA_WIDTH-1:0]     row_next
);

    logic [FEAT_CNT_WIDTH-1:0] word_cnt;
    logic [DATA_WIDTH-1:0]     row_buf;

    // The word arriving when the count equals num_features is the y value.
    assign last = (word_cnt == num_features);

    always_comb begin
        // NOTE: row_next is given a full default before the slot loop so no path leaves it unassigned (no latch).
        row_next = row_buf;
        for (int k = 0; k <= MAX_FEATURES; k++) begin
            if ((last && k == MAX_FEATURES) || (!last && k == int'(word_cnt))) begin
                row_next[k*WORD_WIDTH +: WORD_WIDTH] = word;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            word_cnt <= '0;
            row_buf  <= '0;
        end else if (clear) begin
            word_cnt <= '0;
            row_buf  <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + FEAT_CNT_WIDTH'(1);
            row_buf  <= row_next;
        end
    end

endmodule

// File: rtl/data_point_loader.sv
// Streams feature/y words into packed rows and writes them to a row-wide memory.
// One FSM with registered outputs; word placement is delegated to row_packer.
module data_point_loader
    import data_point_loader_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = DPL_MAX_FEATURES,
    parameter int WORD_WIDTH   = DPL_WORD_WIDTH,
    parameter int DATA_WIDTH   = WORD_WIDTH * (MAX_FEATURES + 1),
    parameter int DEPTH        = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     num_points,
    input  logic [FEAT_CNT_WIDTH-1:0] num_features,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_WIDTH-1:0]     in_data,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    output logic                      ram_we,
    output logic                      ram_oe,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     row_idx;
    logic [ADDR_WIDTH-1:0]     np_q;
    logic [FEAT_CNT_WIDTH-1:0] nf_q;

    logic                  cfg_bad;
    logic                  accept;
    logic                  last_word;
    logic                  last_row;
    logic                  clear;
    logic [DATA_WIDTH-1:0] row_next;

    assign cfg_bad  = (num_points == '0) || (num_points > ADDR_WIDTH'(DEPTH)) ||
                      (num_features == '0) || (num_features > FEAT_CNT_WIDTH'(MAX_FEATURES));
    assign accept   = in_valid && in_ready;
    assign last_row = ((row_idx + ADDR_WIDTH'(1)) == np_q);
    // Buffer is wiped on every entry into COLLECT: from IDLE and from GAP when rows remain.
    assign clear    = ((state == IDLE) && start && !cfg_bad) ||
                      ((state == GAP) && !last_row);
    assign ram_addr = row_idx;

    row_packer #(
        .WORD_WIDTH  (WORD_WIDTH),
        .MAX_FEATURES(MAX_FEATURES),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_row_packer (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .clear       (clear),
        .accept      (accept),
        .word        (in_data),
        .num_features(nf_q),
        .last        (last_word),
        .row_next    (row_next)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            row_idx   <= '0;
            np_q      <= '0;
            nf_q      <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b1;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        np_q <= num_points;
                        nf_q <= num_features;
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end else begin
                            state    <= COLLECT;
                            in_ready <= 1'b1;
                            ram_oe   <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept && last_word) begin
                        state     <= WRITE;
                        in_ready  <= 1'b0;
                        ram_wdata <= row_next;
                        ram_we    <= 1'b1;
                    end
                end
                WRITE: begin
                    state  <= GAP;
                    ram_we <= 1'b0;
                end
                GAP: begin
                    // Row index stays on the last row so it never exceeds DEPTH-1.
                    if (last_row) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state    <= COLLECT;
                        row_idx  <= row_idx + ADDR_WIDTH'(1);
                        in_ready <= 1'b1;
                    end
                end
                FINISH: begin
                    state   <= IDLE;
                    row_idx <= '0;
                    busy    <= 1'b0;
                    ram_oe  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_point_loader.sv
// Directed bench for data_point_loader: loads, config errors, full rows, stalls,
// mid-load reset and start-while-busy, with hand-computed packed rows.
module tb_data_point_loader;

    localparam int AW    = 12;
    localparam int WW    = 16;
    localparam int DW    = 192;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          start;
    logic [AW-1:0] num_points;
    logic [3:0]    num_features;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic          ram_oe;
    logic          busy;
    logic          done;
    logic          err;

    int tests = 0;
    int fails = 0;

    int            we_count;
    int            done_count;
    int            err_count;
    int            busy_count;
    logic          ready_during_we;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] mem [0:DEPTH-1];

    data_point_loader dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .num_points  (num_points),
        .num_features(num_features),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_oe      (ram_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    // Memory-side observer sampled mid-cycle.
    always @(negedge CLK) begin
        if (ram_we) begin
            we_count++;
            mem[ram_addr[1:0]] = ram_wdata;
            last_addr = ram_addr;
            if (in_ready) ready_during_we = 1'b1;
        end
        if (done) done_count++;
        if (err)  err_count++;
        if (busy) busy_count++;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        we_count        = 0;
        done_count      = 0;
        err_count       = 0;
        busy_count      = 0;
        ready_during_we = 1'b0;
        last_addr       = '1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    task automatic do_start(input logic [AW-1:0] np, input logic [3:0] nf);
        start        = 1'b1;
        num_points   = np;
        num_features = nf;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) check("in_ready_wait", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, 1'b1});
        @(negedge CLK);
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
    endtask

    task automatic stall(input int cycles);
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (busy) check("idle_wait", {{(DW-1){1'b0}}, busy}, '0);
        @(negedge CLK);
    endtask

    initial begin
        RST_N        = 1'b0;
        start        = 1'b0;
        num_points   = '0;
        num_features = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        clear_mon();

        // Reset values
        #12;
        check("rst_addr",   ram_addr, '0);
        check("rst_wdata",  ram_wdata, '0);
        check("rst_we",     ram_we, '0);
        check("rst_oe",     ram_oe, 1);
        check("rst_ready",  in_ready, '0);
        check("rst_busy",   busy, '0);
        check("rst_done",   done, '0);
        check("rst_err",    err, '0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Two rows of two features
        clear_mon();
        do_start(12'd2, 4'd2);
        check("a_busy",  busy, 1);
        check("a_ready", in_ready, 1);
        check("a_oe",    ram_oe, '0);
        for (int i = 1; i <= 6; i++) send_word(WW'(i));
        wait_idle();
        check("a_we_count",   we_count, 2);
        check("a_done_count", done_count, 1);
        check("a_row0",       mem[0], {16'd3, 144'd0, 16'd2, 16'd1});
        check("a_row1",       mem[1], {16'd6, 144'd0, 16'd5, 16'd4});
        check("a_ready_we",   ready_during_we, '0);
        check("a_end_addr",   ram_addr, '0);
        check("a_end_oe",     ram_oe, 1);

        // Invalid configurations
        clear_mon();
        do_start(12'd5, 4'd2);
        check("b_err_pulse", err, 1);
        check("b_busy",      busy, '0);
        check("b_ready",     in_ready, '0);
        @(negedge CLK);
        check("b_err_clear", err, '0);
        do_start(12'd0, 4'd1);
        do_start(12'd1, 4'd0);
        do_start(12'd1, 4'd12);
        @(negedge CLK);
        check("b_err_count",  err_count, 4);
        check("b_we_count",   we_count, 0);
        check("b_busy_count", busy_count, 0);

        // All eleven features in one row
        clear_mon();
        do_start(12'd1, 4'd11);
        for (int i = 1; i <= 12; i++) send_word(WW'(i));
        wait_idle();
        check("c_we_count", we_count, 1);
        check("c_row0", mem[0], {16'd12, 16'd11, 16'd10, 16'd9, 16'd8, 16'd7,
                                 16'd6,  16'd5,  16'd4,  16'd3, 16'd2, 16'd1});

        // Stalled stream, buffer must be clean after the full row above
        clear_mon();
        do_start(12'd1, 4'd3);
        send_word(16'h000A);
        stall(2);
        send_word(16'h000B);
        send_word(16'h000C);
        stall(1);
        send_word(16'h000D);
        wait_idle();
        check("d_we_count", we_count, 1);
        check("d_row0", mem[0], {16'h000D, 128'd0, 16'h000C, 16'h000B, 16'h000A});

        // Reset during COLLECT of row 1
        clear_mon();
        do_start(12'd2, 4'd2);
        for (int i = 1; i <= 4; i++) send_word(WW'(i));
        check("e_mid_addr", ram_addr, 1);
        RST_N = 1'b0;
        #1;
        check("e_rst_ready", in_ready, '0);
        check("e_rst_busy",  busy, '0);
        check("e_rst_addr",  ram_addr, '0);
        check("e_rst_wdata", ram_wdata, '0);
        check("e_rst_oe",    ram_oe, 1);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        clear_mon();
        do_start(12'd1, 4'd1);
        send_word(16'd7);
        send_word(16'd8);
        wait_idle();
        check("e_we_count",  we_count, 1);
        check("e_last_addr", last_addr, '0);
        check("e_row0",      mem[0], {16'd8, 160'd0, 16'd7});

        // start pulsed while writing is ignored
        clear_mon();
        do_start(12'd2, 4'd1);
        send_word(16'd1);
        send_word(16'd2);
        check("f_in_write", ram_we, 1);
        do_start(12'd1, 4'd5);
        send_word(16'd3);
        send_word(16'd4);
        wait_idle();
        check("f_we_count",   we_count, 2);
        check("f_done_count", done_count, 1);
        check("f_err_count",  err_count, 0);
        check("f_row0",       mem[0], {16'd2, 160'd0, 16'd1});
        check("f_row1",       mem[1], {16'd4, 160'd0, 16'd3});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_point_loader.md
DATA_POINT_LOADER -- requirements
Module: data_point_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, data-point memory address width.
REQ-002 SHALL have parameter MAX_FEATURES, default 11, maximum features per data point.
REQ-003 SHALL have parameter WORD_WIDTH, default 16, width of one feature or y value.
REQ-004 SHALL have parameter DATA_WIDTH, default WORD_WIDTH*(MAX_FEATURES+1), memory row width.
REQ-005 SHALL have parameter DEPTH, default 4, number of memory rows.
REQ-006 SHALL have port CLK, input, 1, the only clock; all state on rising edge.
REQ-007 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, single-cycle load request.
REQ-009 SHALL have port num_points, input, ADDR_WIDTH, rows to load, sampled on accepted start.
REQ-010 SHALL have port num_features, input, 4, features per row, sampled on accepted start.
REQ-011 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, WORD_WIDTH), word stream.
REQ-012 SHALL have port ram_addr, output, ADDR_WIDTH, memory row address.
REQ-013 SHALL have port ram_wdata, output, DATA_WIDTH, packed row to write.
REQ-014 SHALL have ports ram_we and ram_oe, outputs, 1 each, memory write and output enables.
REQ-015 SHALL have ports busy, done, err, outputs, 1 each, status.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, WRITE, GAP, FINISH.
REQ-017 IDLE: on start=1, SHALL latch num_points/num_features and check them; go COLLECT if valid, else pulse err one cycle and stay IDLE.
REQ-018 Invalid: num_points==0, num_points>DEPTH, num_features==0, num_features>MAX_FEATURES.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 in_ready SHALL be 1 only in COLLECT; a word is accepted when in_valid && in_ready.
REQ-021 Word order per row: feature 0 .. feature num_features-1, then y; num_features+1 words per row.
REQ-022 Feature k SHALL be placed at bits [WORD_WIDTH*k +: WORD_WIDTH]; y at top word [DATA_WIDTH-1 -: WORD_WIDTH]; unused feature slots SHALL be 0.
REQ-023 Row buffer SHALL be cleared on entering COLLECT for each row.
REQ-024 Acceptance of the y word SHALL move COLLECT to WRITE on the next edge (in_ready low that cycle).
REQ-025 WRITE (1 cycle): ram_we=1, ram_addr=row index, ram_wdata=packed row.
REQ-026 GAP (1 cycle): ram_we=0, ram_addr and ram_wdata held; row index increments at GAP exit.
REQ-027 After GAP: if rows written == num_points go FINISH, else COLLECT.
REQ-028 FINISH (1 cycle): done=1, then IDLE; ram_addr returns to 0.
REQ-029 ram_addr SHALL change only on GAP exit or FINISH exit, never while ram_we=1.
REQ-030 ram_oe SHALL be 0 in all states except IDLE, where it is 1.
REQ-031 busy SHALL be 1 in COLLECT, WRITE, GAP, FINISH.
REQ-032 in_valid stall mid-row SHALL hold the word count; no timeout.
REQ-033 Row index counter SHALL be ADDR_WIDTH bits; never exceeds DEPTH-1 due to REQ-018.

Reset
REQ-034 RST_N=0 SHALL asynchronously force IDLE, row index 0, word count 0, row buffer 0.
REQ-035 Reset outputs: ram_addr=0, ram_wdata=0, ram_we=0, ram_oe=1, in_ready=0, busy=0, done=0, err=0.
REQ-036 Reset mid-load SHALL abandon the load; already-written rows are not rolled back.

Structure
REQ-037 FSM state enum, WORD_WIDTH and MAX_FEATURES SHALL live in a shared package used by the memory and datapath.
REQ-038 One sub-module, row_packer (word counter plus row buffer with slot select), SHALL be natural; the FSM stays in data_point_loader.

Verification
REQ-039 num_points=2, num_features=2, words 1,2,3,4,5,6 -> rows: addr0 features 1,2 y=3; addr1 features 4,5 y=6; one we pulse each; done once.
REQ-040 num_points=5 (DEPTH=4) -> err pulse one cycle, ram_we never asserted, busy stays 0.
REQ-041 num_features=11, one row, words 0x0001..0x000C -> ram_wdata all 12 slots filled, y=0x000C in top word.
REQ-042 in_valid toggling 1,0,0,1 mid-row -> only valid words counted, row identical to non-stalled run.
REQ-043 RST_N low during COLLECT of row 1 -> immediate IDLE, reset outputs, next start loads from addr 0.
REQ-044 start pulsed during WRITE -> ignored; num_points unchanged, load completes normally.
